// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared op codes, FSM encoding and JK next-state function
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    IDLE  = 2'b01,
    DRIVE = 2'b10,
    CHECK = 2'b11
  } state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      OP_HOLD:   nq = q;
      OP_RESET:  nq = 1'b0;
      OP_SET:    nq = 1'b1;
      OP_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_ref_model.sv
// rtl/jk_ref_model.sv - registered reference copy of the driven JK flop
module jk_ref_model
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic exp_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else if (en) begin
      exp_q <= jk_next(exp_q, j, k);
    end
  end

endmodule

// File: rtl/jk_stim_driver.sv
// rtl/jk_stim_driver.sv - command-driven J/K stimulus with flop shadow compare
module jk_stim_driver
  import jk_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             err_clr,
  input  logic             q,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             j_nx, k_nx, done_nx;
  logic             armed;

  // Reset drives k=1 so the downstream flop is cleared alongside the model.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      j     <= 1'b0;
      k     <= 1'b1;
      rem   <= '0;
      done  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      j     <= j_nx;
      k     <= k_nx;
      rem   <= rem_nx;
      done  <= done_nx;
      if (state == INIT) begin
        armed <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    j_nx      = 1'b0;
    k_nx      = 1'b0;
    rem_nx    = rem;
    done_nx   = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      INIT: begin
        state_nx = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          {j_nx, k_nx} = cmd_op;
          rem_nx       = cmd_cnt;
          state_nx     = DRIVE;
        end
      end
      DRIVE: begin
        if (rem == '0) begin
          state_nx = CHECK;
        end else begin
          j_nx   = j;
          k_nx   = k;
          rem_nx = rem - CNT_ONE;
        end
      end
      CHECK: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = INIT;
      end
    endcase
  end

  assign busy = (state != IDLE);

  jk_ref_model u_ref (
    .clk   (clk),
    .rst   (rst),
    .en    (state == DRIVE),
    .j     (j),
    .k     (k),
    .exp_q (exp_q)
  );

  // err_clr takes priority over an error seen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (armed && (q != exp_q)) begin
      mismatch <= 1'b1;
      if (err_cnt != {ERR_W{1'b1}}) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_jk_stim_driver.sv
// tb/tb_jk_stim_driver.sv - scoreboard bench for jk_stim_driver with a behavioural JK flop
module tb_jk_stim_driver;
  import jk_pkg::*;

  localparam int CNT_W = 8;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             err_clr = 1'b0;
  logic             q;
  logic             cmd_ready, j, k, busy, done, exp_q, mismatch;
  logic [ERR_W-1:0] err_cnt;

  logic flop_q = 1'b0;
  logic stuck  = 1'b0;
  logic inv    = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         done_cyc;
    logic       q;
    logic       exp_q;
    logic       mm;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  jk_stim_driver #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .err_clr   (err_clr),
    .q         (q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .exp_q     (exp_q),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the real flop; stuck and inv let the bench inject faults.
  always @(posedge clk) begin
    if (!stuck) begin
      case ({j, k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  assign q = flop_q ^ inv;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done pulsed with no command pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.done_cyc);
        chk("done_q", int'(q), int'(mon_e.q));
        chk("done_exp_q", int'(exp_q), int'(mon_e.exp_q));
        chk("done_mismatch", int'(mismatch), int'(mon_e.mm));
        chk("done_err_cnt", int'(err_cnt), int'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] cnt, input bit push,
                      input logic eq, input logic ee, input logic em, input logic [7:0] eerr);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: cmd_ready %0d after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.done_cyc = cyc + int'(cnt) + 3;
      e.q        = eq;
      e.exp_q    = ee;
      e.mm       = em;
      e.err      = eerr;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_cnt   = ~cnt;
    chk("drive_j", int'(j), int'(op[1]));
    chk("drive_k", int'(k), int'(op[0]));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending %0d busy %0d, required 0 0", sb.size(), busy);
    end
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_j", int'(j), 0);
    chk("rst_k", int'(k), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_exp_q", int'(exp_q), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_done", int'(done), 0);

    rst = 1'b0;
    #1;
    chk("init_busy", int'(busy), 1);
    chk("init_ready", int'(cmd_ready), 0);
    chk("init_k", int'(k), 1);
    @(negedge clk);
    chk("idle_j", int'(j), 0);
    chk("idle_k", int'(k), 0);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_q", int'(q), 0);
    chk("idle_exp_q", int'(exp_q), 0);
    chk("idle_mismatch", int'(mismatch), 0);

    send(OP_SET,    8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    send(OP_RESET,  8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send(OP_TOGGLE, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    send(OP_RESET,  8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send(OP_HOLD,   8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_idle();

    // Stuck flop during SET: 4 mismatching edges, then 2 more before RESET realigns.
    stuck = 1'b1;
    send(OP_SET,   8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    send(OP_RESET, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd6);
    wait_idle();
    stuck = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_mismatch", int'(mismatch), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);

    send(OP_TOGGLE, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_j", int'(j), 0);
    chk("midrst_k", int'(k), 1);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_ready", int'(cmd_ready), 0);
    chk("midrst_exp_q", int'(exp_q), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_q", int'(q), 0);
    chk("post_rst_mismatch", int'(mismatch), 0);
    send(OP_SET, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_idle();

    inv = 1'b1;
    repeat (260) @(negedge clk);
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_mismatch", int'(mismatch), 1);
    repeat (40) @(negedge clk);
    chk("sat_hold", int'(err_cnt), 255);
    inv = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("sat_clr_err_cnt", int'(err_cnt), 0);
    chk("sat_clr_mismatch", int'(mismatch), 0);

    send(OP_TOGGLE, 8'd255, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_stim_driver.md
Name: jk_stim_driver

Overview:
- Upstream driver for the single-bit jk_ff (ports j, k, clk, q).
- Accepts {op, repeat-count} commands over a valid/ready handshake and drives registered j/k for the requested number of clock edges.
- Keeps a reference model of the flop, compares it with the q fed back from the flop, and reports sticky mismatch and a saturating error count.

Parameters:
- CNT_W, 8, width of cmd_cnt; a command applies cmd_cnt+1 edges.
- ERR_W, 8, width of err_cnt; the counter saturates at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a rising edge.
- cmd_op  in  2  {j,k} encoding: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_cnt  in  CNT_W  repeat count minus one.
- err_clr  in  1  clears mismatch and err_cnt.
- q  in  1  flop output fed back.
- j  out  1  registered J to flop.
- k  out  1  registered K to flop.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on command completion.
- exp_q  out  1  model-predicted q.
- mismatch  out  1  sticky compare failure.
- err_cnt  out  ERR_W  mismatching-cycle count, saturating.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). Every register updates only on rising clk; rst overrides all other inputs.
- Values while rst is high: j=0, k=1 (forces a RESET into the flop), state=INIT, exp_q=0, mismatch=0, err_cnt=0, done=0, armed=0, busy=1, cmd_ready=0.
- FSM has four states: INIT, IDLE, DRIVE, CHECK.
- INIT:
  - Lasts exactly one cycle after rst falls, with j=0, k=1.
  - The edge leaving INIT sets armed=1 and j=k=0, then moves to IDLE. The flop now holds q=0.
- IDLE:
  - j=k=0; cmd_ready=1 combinationally.
  - On handshake: j,k<=cmd_op; rem<=cmd_cnt; state->DRIVE.
- DRIVE:
  - At each edge, exp_q<=jk_next(exp_q, j, k).
  - If rem==0: j=k<=0 and state->CHECK. Otherwise rem<=rem-1.
  - Total edges applied = cmd_cnt+1.
- CHECK: one settle cycle with j=k=0. Next edge goes to IDLE with done=1 for that first IDLE cycle.
- Command latency: accept edge E0, last drive edge E(cnt+1), done high in the cycle after E(cnt+2).
- A command may be accepted in the same cycle that done is high (back-to-back).
- cmd_ready=0 in INIT, DRIVE and CHECK; cmd_valid held during those states waits and loses nothing.
- jk_next(q, j, k): 00 keeps q, 01 gives 0, 10 gives 1, 11 gives ~q.
- Compare:
  - At every edge with armed=1 and rst=0, if q!=exp_q: mismatch<=1 and err_cnt<=sat_inc(err_cnt).
  - err_clr=1 clears both, and wins over a same-cycle error.
  - No compare while armed=0 (rst, INIT).
- Boundaries:
  - cmd_cnt=0 gives one edge; cmd_cnt=all-ones gives 2^CNT_W edges.
  - err_cnt holds at 2^ERR_W-1.
  - rst mid-DRIVE: on the next cycle j=0, k=1, state=INIT, rem discarded, done not pulsed.
  - cmd_op/cmd_cnt are sampled only at the handshake edge; later changes are ignored.

Decomposition:
- Package jk_pkg holds:
  - localparams OP_HOLD=2'b00, OP_RESET=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11;
  - the state encoding (INIT, IDLE, DRIVE, CHECK);
  - the function jk_next.
- One sub-module, jk_ref_model:
  - registered exp_q with synchronous reset to 0;
  - inputs clk, rst, en, j, k.
  - Instanced once.
- FSM, counter and compare logic stay in the top level.

Test Plan:
- Reset and INIT: hold rst 3 cycles -> j=0, k=1, busy=1, cmd_ready=0. Release -> one INIT cycle, then IDLE with j=k=0, q=0, exp_q=0, mismatch=0.
- SET, cnt=0: accept at E0 -> j=1, k=0 for one cycle. q=1, exp_q=1 after E1. done high in the cycle after E2.
- TOGGLE, cnt=4 from q=0: 5 edges with q=1,0,1,0,1. busy 6 cycles. Final q=exp_q=1. err_cnt=0.
- Fault injection: stub flop ignores j and stays q=0 during SET cnt=3 -> mismatch=1, err_cnt=4 after CHECK. err_clr pulse -> 0/0.
- rst mid-TOGGLE cnt=200 at edge 50 -> next cycle j=0, k=1, state=INIT, no done, err_cnt=0. Normal IDLE follows.
- Handshake: cmd_valid held across a busy SET -> second command (RESET) accepted in the done cycle, then q=0. Forced mismatch for 300 cycles -> err_cnt=255 and holds.
